// File: rtl/vend_pkg.sv
// Shared vending definitions: coin codes used by the FSM and the change
// dispenser, plus the dispenser state encoding.
package vend_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_LO   = 2'b01;
  localparam logic [1:0] COIN_MID  = 2'b10;
  localparam logic [1:0] COIN_HI   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_DONE   = 3'd3,
    ST_SHORT  = 3'd4
  } disp_state_t;

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin picker: highest denomination that fits the remaining value and
// is still in stock. Purely combinational.
module change_coin_select
  import vend_pkg::*;
#(
  parameter int AMT_W   = 8,
  parameter int STOCK_W = 6,
  parameter int VAL_LO  = 5,
  parameter int VAL_MID = 10,
  parameter int VAL_HI  = 25
) (
  input  logic [AMT_W-1:0]   remaining,
  input  logic [STOCK_W-1:0] stock_lo,
  input  logic [STOCK_W-1:0] stock_mid,
  input  logic [STOCK_W-1:0] stock_hi,
  output logic [1:0]         code,
  output logic               none_available
);

  localparam logic [AMT_W-1:0]   VAL_LO_A   = AMT_W'(VAL_LO);
  localparam logic [AMT_W-1:0]   VAL_MID_A  = AMT_W'(VAL_MID);
  localparam logic [AMT_W-1:0]   VAL_HI_A   = AMT_W'(VAL_HI);
  localparam logic [STOCK_W-1:0] STOCK_ZERO = {STOCK_W{1'b0}};

  // Priority pick, largest coin first.
  always_comb begin
    code           = COIN_NONE;
    none_available = 1'b1;
    if ((stock_hi != STOCK_ZERO) && (VAL_HI_A <= remaining)) begin
      code           = COIN_HI;
      none_available = 1'b0;
    end else if ((stock_mid != STOCK_ZERO) && (VAL_MID_A <= remaining)) begin
      code           = COIN_MID;
      none_available = 1'b0;
    end else if ((stock_lo != STOCK_ZERO) && (VAL_LO_A <= remaining)) begin
      code           = COIN_LO;
      none_available = 1'b0;
    end else begin
      code           = COIN_NONE;
      none_available = 1'b1;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change/refund payout engine: pays an amount greedily from per-denomination
// stock, one coin per valid/ready handshake with the hopper.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W      = 8,
  parameter int STOCK_W    = 6,
  parameter int VAL_LO     = 5,
  parameter int VAL_MID    = 10,
  parameter int VAL_HI     = 25,
  parameter int INIT_STOCK = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               refund_mode,
  input  logic [AMT_W-1:0]   amount,
  input  logic               restock,
  input  logic               coin_ready,
  output logic               coin_valid,
  output logic [1:0]         coin_code,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [AMT_W-1:0]   shortfall,
  output logic               refund_flag,
  output logic [STOCK_W-1:0] stock_lo,
  output logic [STOCK_W-1:0] stock_mid,
  output logic [STOCK_W-1:0] stock_hi
);

  localparam logic [AMT_W-1:0]   VAL_LO_A   = AMT_W'(VAL_LO);
  localparam logic [AMT_W-1:0]   VAL_MID_A  = AMT_W'(VAL_MID);
  localparam logic [AMT_W-1:0]   VAL_HI_A   = AMT_W'(VAL_HI);
  localparam logic [AMT_W-1:0]   AMT_ZERO   = {AMT_W{1'b0}};
  localparam logic [STOCK_W-1:0] STOCK_INIT = STOCK_W'(INIT_STOCK);
  localparam logic [STOCK_W-1:0] STOCK_ONE  = STOCK_W'(1);

  disp_state_t        state_r, state_s;
  logic [AMT_W-1:0]   remaining_r, remaining_s;
  logic [1:0]         code_r, code_s;
  logic               refund_r, refund_s;
  logic [STOCK_W-1:0] stock_lo_r, stock_lo_s;
  logic [STOCK_W-1:0] stock_mid_r, stock_mid_s;
  logic [STOCK_W-1:0] stock_hi_r, stock_hi_s;
  logic               coin_valid_r, busy_r, done_r, short_r;
  logic [1:0]         coin_code_r;
  logic [AMT_W-1:0]   shortfall_r;
  logic [1:0]         sel_code_s;
  logic               sel_none_s;

  change_coin_select #(
    .AMT_W  (AMT_W),
    .STOCK_W(STOCK_W),
    .VAL_LO (VAL_LO),
    .VAL_MID(VAL_MID),
    .VAL_HI (VAL_HI)
  ) u_select (
    .remaining     (remaining_r),
    .stock_lo      (stock_lo_r),
    .stock_mid     (stock_mid_r),
    .stock_hi      (stock_hi_r),
    .code          (sel_code_s),
    .none_available(sel_none_s)
  );

  // Next-state, datapath and stock update logic.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    code_s      = code_r;
    refund_s    = refund_r;
    stock_lo_s  = stock_lo_r;
    stock_mid_s = stock_mid_r;
    stock_hi_s  = stock_hi_r;
    case (state_r)
      ST_IDLE: begin
        if (restock) begin
          stock_lo_s  = STOCK_INIT;
          stock_mid_s = STOCK_INIT;
          stock_hi_s  = STOCK_INIT;
        end else begin
          stock_lo_s  = stock_lo_r;
        end
        if (start) begin
          remaining_s = amount;
          refund_s    = refund_mode;
          state_s     = ST_SELECT;
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_SELECT: begin
        if (remaining_r == AMT_ZERO) begin
          state_s = ST_DONE;
        end else if (sel_none_s) begin
          state_s = ST_SHORT;
        end else begin
          code_s  = sel_code_s;
          state_s = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // The picker guaranteed value <= remaining and stock > 0 for code_r.
        if (coin_valid_r && coin_ready) begin
          state_s = ST_SELECT;
          case (code_r)
            COIN_HI: begin
              remaining_s = remaining_r - VAL_HI_A;
              stock_hi_s  = stock_hi_r - STOCK_ONE;
            end
            COIN_MID: begin
              remaining_s = remaining_r - VAL_MID_A;
              stock_mid_s = stock_mid_r - STOCK_ONE;
            end
            COIN_LO: begin
              remaining_s = remaining_r - VAL_LO_A;
              stock_lo_s  = stock_lo_r - STOCK_ONE;
            end
            default: begin
              remaining_s = remaining_r;
            end
          endcase
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_DONE:  state_s = ST_IDLE;
      ST_SHORT: state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      remaining_r  <= AMT_ZERO;
      code_r       <= COIN_NONE;
      refund_r     <= 1'b0;
      stock_lo_r   <= STOCK_INIT;
      stock_mid_r  <= STOCK_INIT;
      stock_hi_r   <= STOCK_INIT;
      coin_valid_r <= 1'b0;
      coin_code_r  <= COIN_NONE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      short_r      <= 1'b0;
      shortfall_r  <= AMT_ZERO;
    end else begin
      state_r      <= state_s;
      remaining_r  <= remaining_s;
      code_r       <= code_s;
      refund_r     <= refund_s;
      stock_lo_r   <= stock_lo_s;
      stock_mid_r  <= stock_mid_s;
      stock_hi_r   <= stock_hi_s;
      coin_valid_r <= (state_s == ST_ISSUE);
      coin_code_r  <= (state_s == ST_ISSUE) ? code_s : COIN_NONE;
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
      short_r      <= (state_s == ST_SHORT);
      shortfall_r  <= (state_s == ST_SHORT) ? remaining_s : AMT_ZERO;
    end
  end

  assign coin_valid  = coin_valid_r;
  assign coin_code   = coin_code_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign short       = short_r;
  assign shortfall   = shortfall_r;
  assign refund_flag = refund_r;
  assign stock_lo    = stock_lo_r;
  assign stock_mid   = stock_mid_r;
  assign stock_hi    = stock_hi_r;

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a bench-side greedy model predicts
// coins and completion events, a negedge monitor compares them.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset, start, refund_mode, restock, coin_ready;
  logic [7:0] amount;
  logic       coin_valid, busy, done, short, refund_flag;
  logic [1:0] coin_code;
  logic [7:0] shortfall;
  logic [5:0] stock_lo, stock_mid, stock_hi;

  typedef struct packed {
    logic       is_short;
    logic [7:0] sf;
  } end_t;

  logic [1:0] exp_coin[$];
  end_t       exp_end[$];
  int m_lo, m_mid, m_hi;
  int n_checks = 0;
  int n_fail = 0;
  int end_count = 0;
  int hs_count = 0;

  change_dispenser dut (
    .clk(clk), .reset(reset), .start(start), .refund_mode(refund_mode),
    .amount(amount), .restock(restock), .coin_ready(coin_ready),
    .coin_valid(coin_valid), .coin_code(coin_code), .busy(busy), .done(done),
    .short(short), .shortfall(shortfall), .refund_flag(refund_flag),
    .stock_lo(stock_lo), .stock_mid(stock_mid), .stock_hi(stock_hi)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: coin handshakes and completion pulses against the scoreboard.
  always @(negedge clk) begin
    if (!coin_valid) check_val("code_idle_zero", {30'd0, coin_code}, 32'd0);
    if (!short) check_val("shortfall_idle_zero", {24'd0, shortfall}, 32'd0);
    if (coin_valid && coin_ready) begin
      hs_count++;
      if (exp_coin.size() == 0) check_val("coin_unexpected", 32'd1, 32'd0);
      else check_val("coin_code", {30'd0, coin_code}, {30'd0, exp_coin.pop_front()});
    end
    if (done || short) begin
      end_count++;
      if (exp_end.size() == 0) check_val("end_unexpected", 32'd1, 32'd0);
      else begin
        end_t e;
        e = exp_end.pop_front();
        check_val("done_pulse", {31'd0, done}, {31'd0, ~e.is_short});
        check_val("short_pulse", {31'd0, short}, {31'd0, e.is_short});
        check_val("shortfall", {24'd0, shortfall}, {24'd0, e.sf});
      end
    end
  end

  task automatic predict(input int amt);
    int rem;
    rem = amt;
    while (rem > 0) begin
      if (m_hi > 0 && rem >= 25) begin exp_coin.push_back(2'b11); m_hi--; rem -= 25; end
      else if (m_mid > 0 && rem >= 10) begin exp_coin.push_back(2'b10); m_mid--; rem -= 10; end
      else if (m_lo > 0 && rem >= 5) begin exp_coin.push_back(2'b01); m_lo--; rem -= 5; end
      else break;
    end
    exp_end.push_back('{is_short: (rem != 0), sf: rem[7:0]});
  endtask

  task automatic start_pay(input int amt, input logic rf);
    @(posedge clk); #1;
    start = 1'b1; amount = amt[7:0]; refund_mode = rf;
    predict(amt);
    @(posedge clk); #1;
    start = 1'b0; refund_mode = 1'b0;
  endtask

  task automatic wait_end();
    int c0;
    bit seen;
    c0 = end_count;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      if (end_count != c0) begin seen = 1'b1; break; end
    end
    #1;
    check_val("end_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic check_stock(input string tag);
    check_val({tag, "_stock_lo"}, {26'd0, stock_lo}, m_lo);
    check_val({tag, "_stock_mid"}, {26'd0, stock_mid}, m_mid);
    check_val({tag, "_stock_hi"}, {26'd0, stock_hi}, m_hi);
    check_val({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic do_restock();
    @(posedge clk); #1 restock = 1'b1;
    @(posedge clk); #1 restock = 1'b0;
    m_lo = 20; m_mid = 20; m_hi = 20;
  endtask

  initial begin
    int h0;
    reset = 1'b1; start = 1'b0; refund_mode = 1'b0; restock = 1'b0;
    coin_ready = 1'b1; amount = 8'd0;
    m_lo = 20; m_mid = 20; m_hi = 20;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_outputs", {coin_valid, coin_code, busy, done, short, refund_flag}, 32'd0);
    check_stock("rst");
    reset = 1'b0;

    // Exact greedy path with latency check.
    start_pay(40, 1'b0);
    check_val("lat_n1_valid", {31'd0, coin_valid}, 32'd0);
    check_val("lat_n1_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    check_val("lat_n2_valid", {31'd0, coin_valid}, 32'd1);
    wait_end();
    check_stock("greedy40");
    check_val("greedy_hi19", {26'd0, stock_hi}, 32'd19);

    // Zero amount, then shortfalls.
    start_pay(0, 1'b0);  wait_end();
    start_pay(3, 1'b1);  wait_end();
    check_val("refund_latched", {31'd0, refund_flag}, 32'd1);
    start_pay(12, 1'b0); wait_end();
    check_stock("short12");

    // Backpressure.
    coin_ready = 1'b0;
    h0 = hs_count;
    start_pay(25, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      check_val("bp_valid", {31'd0, coin_valid}, 32'd1);
      check_val("bp_code", {30'd0, coin_code}, 32'd3);
      @(posedge clk); #1;
    end
    coin_ready = 1'b1;
    wait_end();
    check_val("bp_one_coin", hs_count - h0, 32'd1);
    check_stock("bp");

    // Ignored start and restock while busy.
    coin_ready = 1'b0;
    start_pay(40, 1'b1);
    @(posedge clk); #1;
    start = 1'b1; amount = 8'd99; restock = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; restock = 1'b0; coin_ready = 1'b1;
    wait_end();
    repeat (4) @(posedge clk);
    #1;
    check_stock("ignored");
    check_val("ignored_refund", {31'd0, refund_flag}, 32'd1);

    // Stock fallback: drain the 25 coins, then pay 50 from tens.
    do_restock();
    check_stock("restock");
    start_pay(250, 1'b0); wait_end();
    start_pay(250, 1'b0); wait_end();
    check_val("hi_drained", {26'd0, stock_hi}, 32'd0);
    start_pay(50, 1'b0); wait_end();
    check_stock("fallback");
    check_val("fallback_mid15", {26'd0, stock_mid}, 32'd15);

    // Reset in the middle of an issue.
    coin_ready = 1'b0;
    start_pay(25, 1'b0);
    @(posedge clk); #1;
    check_val("pre_rst_valid", {31'd0, coin_valid}, 32'd1);
    reset = 1'b1;
    #1;
    check_val("midrst_outputs", {coin_valid, coin_code, busy, done, short, refund_flag}, 32'd0);
    check_val("midrst_shortfall", {24'd0, shortfall}, 32'd0);
    exp_coin.delete(); exp_end.delete();
    m_lo = 20; m_mid = 20; m_hi = 20;
    check_stock("midrst");
    @(posedge clk); #1;
    reset = 1'b0; coin_ready = 1'b1;
    start_pay(5, 1'b0); wait_end();
    check_stock("after_rst");

    check_val("coin_queue_empty", exp_coin.size(), 32'd0);
    check_val("end_queue_empty", exp_end.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
